// File: rtl/fifo_drain_arb_pkg.sv
// Shared types for the lookahead-FIFO drain arbiter.
package fifo_drain_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fifo_drain_state_t;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_drain_arb_if.sv
// Request/grant bundle between the arbiter core and its round-robin picker.
interface fifo_drain_arb_if #(
  parameter int num_req_p = 4
);
  localparam int IDX_W = $clog2(num_req_p);

  logic [num_req_p-1:0] req;
  logic [IDX_W-1:0]     ptr;
  logic [num_req_p-1:0] gnt;
  logic [IDX_W-1:0]     idx;

  modport master (output req, output ptr, input gnt, input idx);
  modport slave  (input req, input ptr, output gnt, output idx);
endinterface

// File: rtl/fifo_drain_arb_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping; one-hot grant plus index.
module rr_pick #(
  parameter int num_req_p = 4
) (
  fifo_drain_arb_if.slave pick
);
  localparam int IDX_W = $clog2(num_req_p);

  always_comb begin
    int  k;
    logic found;
    k        = 0;
    found    = 1'b0;
    pick.gnt = '0;
    pick.idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      k = int'(pick.ptr) + i;
      if (k >= num_req_p) k = k - num_req_p;
      if (!found && pick.req[k]) begin
        found       = 1'b1;
        pick.gnt[k] = 1'b1;
        pick.idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arb.sv
// Drains num_req_p lookahead FIFOs round-robin into a credit-limited downstream buffer.
// Optional issued-entry counter built only with FIFO_DRAIN_ARB_STATS_EN.
module fifo_drain_arb
  import fifo_drain_arb_pkg::*;
#(
  parameter int num_req_p    = 4,
  parameter int data_width_p = 32,
  parameter int credits_p    = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              empty_i,
  input  logic [num_req_p*data_width_p-1:0] rd_data_i,
  output logic [num_req_p-1:0]              rd_o,
  input  logic                              flush_i,
  input  logic                              credit_ret_i,
  output logic                              valid_o,
  output logic [data_width_p-1:0]           data_o,
  output logic [$clog2(num_req_p)-1:0]      src_o,
  output logic                              flush_busy_o,
  output logic [31:0]                       issue_cnt_o
);
  localparam int IDX_W = $clog2(num_req_p);
  localparam int CRD_W = $clog2(credits_p + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(credits_p);

  // Flow control: an entry may only be issued while a downstream credit is held;
  // valid_o is a one-cycle strobe with no back-pressure, credit_ret_i returns one slot.

  fifo_drain_state_t       state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CRD_W-1:0]        credit_q, credit_d;
  logic                    valid_q, valid_d;
  logic [data_width_p-1:0] data_q, data_d;
  logic [IDX_W-1:0]        src_q, src_d;
  logic                    grant;
  logic                    ret_ok;

  fifo_drain_arb_if #(.num_req_p(num_req_p)) pick_if ();
  rr_pick #(.num_req_p(num_req_p)) u_rr_pick (.pick(pick_if));

  assign pick_if.req = ~empty_i;
  assign pick_if.ptr = rr_ptr_q;

  always_comb begin
    grant  = (state_q == RUN) && !flush_i && (credit_q != '0) && (|(~empty_i));
    ret_ok = credit_ret_i && (credit_q != CRD_MAX);

    rd_o = '0;
    if (!reset_i) begin
      if (state_q == FLUSH) rd_o = ~empty_i;
      else if (grant)       rd_o = pick_if.gnt;
    end

    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    valid_d  = grant;
    data_d   = data_q;
    src_d    = src_q;
    credit_d = credit_q;

    case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d  = FLUSH;
          rr_ptr_d = '0;
        end else if (grant) begin
          data_d   = rd_data_i[pick_if.idx*data_width_p +: data_width_p];
          src_d    = pick_if.idx;
          rr_ptr_d = IDX_W'(rr_next(32'(pick_if.idx), num_req_p));
        end
      end
      FLUSH: begin
        if (!flush_i && (&empty_i)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // A return that arrives with credits full is spurious and dropped.
    case ({grant, ret_ok})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= RUN;
      rr_ptr_q <= '0;
      credit_q <= CRD_MAX;
      valid_q  <= 1'b0;
      data_q   <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      src_q    <= src_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign src_o        = src_q;
  assign flush_busy_o = (state_q == FLUSH);

`ifdef FIFO_DRAIN_ARB_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;

  assign issue_cnt_d = issue_cnt_q + 32'(grant);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) issue_cnt_q <= '0;
    else         issue_cnt_q <= issue_cnt_d;
  end

  assign issue_cnt_o = issue_cnt_q;
`else
  assign issue_cnt_o = '0;
`endif

endmodule
